// File: rtl/mode_addsub_serial.sv
// Digit-serial two's-complement adder/subtractor, LSB first, DIGIT bits per clock.
// Optional feature: define ADDSUB_SATURATE_EN to clamp o_sum on signed overflow.
module mode_addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_neg
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("mode_addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [WIDTH-1:0]   res_reg, res_next;
    logic               carry_reg, carry_next;
    logic               a_msb_reg, a_msb_next;
    logic               b_msb_reg, b_msb_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   sum_reg, sum_next;
    logic               valid_reg, valid_next;
    logic               cout_reg, cout_next;
    logic               ovf_reg, ovf_next;
    logic               zero_reg, zero_next;
    logic               neg_reg, neg_next;

    // Ripple chain across one digit; chain[0] is the carry saved from the previous digit.
    logic [DIGIT:0]     chain;
    logic [DIGIT-1:0]   digit_sum;
    assign chain[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_digit
            assign digit_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ chain[gi];
            assign chain[gi+1]   = (a_reg[gi] & b_reg[gi]) | (chain[gi] & (a_reg[gi] ^ b_reg[gi]));
        end
    endgenerate

    // New digit enters from the top so that after N steps the LSB digit sits at bit 0.
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] final_sum;
    logic             raw_ovf;
    assign res_shift = (res_reg >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
    assign raw_ovf   = (a_msb_reg == b_msb_reg) && (res_shift[WIDTH-1] != a_msb_reg);

`ifdef ADDSUB_SATURATE_EN
    always_comb begin
        final_sum = res_shift;
        if (raw_ovf) begin
            final_sum = a_msb_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign final_sum = res_shift;
`endif

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        res_next   = res_reg;
        carry_next = carry_reg;
        a_msb_next = a_msb_reg;
        b_msb_next = b_msb_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        valid_next = valid_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;
        zero_next  = zero_reg;
        neg_next   = neg_reg;
        case (state_reg)
            IDLE: begin
                if (i_valid) begin
                    a_next     = i_a;
                    b_next     = i_b ^ {WIDTH{i_mode}};
                    carry_next = i_mode;
                    a_msb_next = i_a[WIDTH-1];
                    b_msb_next = i_b[WIDTH-1] ^ i_mode;
                    cnt_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                a_next     = a_reg >> DIGIT;
                b_next     = b_reg >> DIGIT;
                carry_next = chain[DIGIT];
                res_next   = res_shift;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(N - 1)) begin
                    sum_next   = final_sum;
                    cout_next  = chain[DIGIT];
                    ovf_next   = raw_ovf;
                    zero_next  = (final_sum == '0);
                    neg_next   = final_sum[WIDTH-1];
                    valid_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            valid_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
            neg_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            carry_reg <= carry_next;
            a_msb_reg <= a_msb_next;
            b_msb_reg <= b_msb_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            valid_reg <= valid_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
            zero_reg  <= zero_next;
            neg_reg   <= neg_next;
        end
    end

    assign o_ready    = (state_reg == IDLE);
    assign o_valid    = valid_reg;
    assign o_sum      = sum_reg;
    assign o_carry    = cout_reg;
    assign o_overflow = ovf_reg;
    assign o_zero     = zero_reg;
    assign o_neg      = neg_reg;

endmodule
